// File: rtl/vga_vmem_slave.sv
// WISHBONE 32-bit memory slave for the VGA master: single cycles, CAB linear
// bursts, programmable wait states, ERR_O outside the address window.
module vga_vmem_slave #(
  parameter int               AW         = 10,
  parameter logic [29-AW:0]   BASE       = '0,
  parameter int               WAIT_FIRST = 2,
  parameter int               WAIT_BURST = 0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        CAB_I,
  input  logic        WE_I,
  input  logic [29:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_d;
  logic [29:0] adr_q;
  logic        we_q, err_q, ack_q, ack_d;
  logic [3:0]  wcnt, wcnt_d;
  logic        cap, adv, wr, hit;
  logic [29:0] adr_nxt;

  logic [31:0] mem [2**AW];

  function automatic logic in_range(input logic [29:0] a);
    return a[29:AW] == BASE;
  endfunction

  assign adr_nxt = adr_q + 30'd1;
  // The master still presents the beat we are serving.
  assign hit     = CYC_I & STB_I & (ADR_I == adr_q);
  assign ACK_O   = ack_q & ~err_q & hit;
  assign ERR_O   = ack_q &  err_q & hit;

  // Next-state logic: capture, wait countdown, response and burst advance.
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    ack_d   = 1'b0;
    cap     = 1'b0;
    adv     = 1'b0;
    wr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (CYC_I && STB_I) begin
          cap = 1'b1;
          if (WAIT_FIRST == 0) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
          end else begin
            wcnt_d  = 4'(WAIT_FIRST - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!hit) begin
          state_d = S_IDLE;
        end else if (wcnt == 4'd0) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (ACK_O || ERR_O) begin
          wr = ACK_O & we_q;
          if (CAB_I && !err_q) begin
            adv = 1'b1;
            if (WAIT_BURST == 0) begin
              state_d = S_RESP;
              ack_d   = 1'b1;
            end else begin
              wcnt_d  = 4'(WAIT_BURST - 1);
              state_d = S_WAIT;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers and the synchronous read port (capture or prefetch).
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= S_IDLE;
      adr_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      wcnt  <= '0;
      DAT_O <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
      ack_q <= ack_d;
      if (cap) begin
        adr_q <= ADR_I;
        we_q  <= WE_I;
        err_q <= ~in_range(ADR_I);
        DAT_O <= mem[ADR_I[AW-1:0]];
      end else if (adv) begin
        adr_q <= adr_nxt;
        we_q  <= WE_I;
        err_q <= ~in_range(adr_nxt);
        DAT_O <= mem[adr_nxt[AW-1:0]];
      end
    end
  end

  // Byte-lane write on an acknowledged write beat; contents survive reset.
  always_ff @(posedge CLK_I) begin
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (SEL_I[b]) mem[adr_q[AW-1:0]][8*b +: 8] <= DAT_I[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_vga_vmem_slave.sv
// Scoreboard bench for vga_vmem_slave: master tasks push expected responses,
// a negedge monitor pops and compares on every ACK_O/ERR_O.
module tb_vga_vmem_slave;

  localparam int WF = 2;

  logic        clk = 1'b0;
  logic        RST_I = 1'b0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, CAB_I = 1'b0, WE_I = 1'b0;
  logic [29:0] ADR_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O, ERR_O;

  vga_vmem_slave #(.AW(10), .BASE('0), .WAIT_FIRST(WF), .WAIT_BURST(0)) dut (
    .CLK_I(clk), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .CAB_I(CAB_I),
    .WE_I(WE_I), .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] dat;
    bit          chk;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every terminated beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!RST_I && (ACK_O || ERR_O)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: cyc %0d ack %0b err %0b dat %h, expected none",
                 cyc, ACK_O, ERR_O, DAT_O);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || ERR_O !== e.err || ACK_O !== !e.err ||
            (e.chk && !e.err && DAT_O !== e.dat)) begin
          n_fail++;
          $display("FAIL resp: cyc %0d err %0b dat %h, expected cyc %0d err %0b dat %h",
                   cyc, ERR_O, DAT_O, e.cyc, e.err, e.dat);
        end
      end
    end
  end

  task automatic drv(input bit c, s, cab, we, input logic [29:0] a,
                     input logic [3:0] sel, input logic [31:0] d);
    CYC_I = c; STB_I = s; CAB_I = cab; WE_I = we; ADR_I = a; SEL_I = sel; DAT_I = d;
  endtask

  task automatic push(input int c, input bit err, input logic [31:0] d, input bit chk);
    exp_t e;
    e.cyc = c; e.err = err; e.dat = d; e.chk = chk;
    q.push_back(e);
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ACK_O || ERR_O) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no response at adr %h, expected one within 20 cycles", ADR_I);
    end
  endtask

  task automatic single(input bit we, input logic [29:0] a, input logic [3:0] sel,
                        input logic [31:0] d, input logic [31:0] exp_d, input bit exp_err);
    bit ok;
    @(posedge clk); #1;
    drv(1, 1, 0, we, a, sel, d);
    push(cyc + WF + 1, exp_err, exp_d, !we);
    wait_resp(ok);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, '0, '0, '0);
  endtask

  // Linear CAB burst; data/expected read value equals the word address.
  task automatic burst(input bit we, input logic [29:0] a0, input int n,
                       input int err_beat, input int rst_beat);
    bit ok;
    logic [29:0] a;
    @(posedge clk); #1;
    drv(1, 1, 1, we, a0, 4'hF, {2'b00, a0});
    push(cyc + WF + 1, err_beat == 0, {2'b00, a0}, !we);
    for (int b = 0; b < n; b++) begin
      wait_resp(ok);
      if (!ok) break;
      if (rst_beat == b) begin
        #2 RST_I = 1'b1;
        #1;
        check("rst_ack", {31'd0, ACK_O}, 32'd0);
        check("rst_err", {31'd0, ERR_O}, 32'd0);
        check("rst_dat", DAT_O, 32'd0);
        break;
      end
      if (b == n - 1 || err_beat == b) break;
      @(posedge clk); #1;
      a = a0 + 30'(b + 1);
      drv(1, 1, 1, we, a, 4'hF, {2'b00, a});
      push(cyc, err_beat == b + 1, {2'b00, a}, !we);
    end
    @(posedge clk); #1;
    drv(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("post_burst_ack", {30'd0, ACK_O, ERR_O}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST_I = 1'b1;
    #1;
    check("reset_ack", {31'd0, ACK_O}, 32'd0);
    check("reset_err", {31'd0, ERR_O}, 32'd0);
    check("reset_dat", DAT_O, 32'd0);
    repeat (3) @(posedge clk);
    #1 RST_I = 1'b0;

    // Preload through the bus.
    single(1, 30'h005, 4'hF, 32'hA5A5_0005, '0, 0);
    burst(1, 30'h010, 8, -1, -1);
    single(1, 30'h020, 4'hF, 32'hFFFF_FFFF, '0, 0);
    single(1, 30'h030, 4'hF, 32'hDEAD_0030, '0, 0);
    single(1, 30'h3FE, 4'hF, 32'h0000_03FE, '0, 0);
    single(1, 30'h3FF, 4'hF, 32'h0000_03FF, '0, 0);

    // Single read, first-beat latency WF+1.
    single(0, 30'h005, 4'h0, '0, 32'hA5A5_0005, 0);
    // 8-beat zero-wait read burst, ACK every cycle.
    burst(0, 30'h010, 8, -1, -1);
    // Burst across the window end: ACK 0x3FE, 0x3FF, ERR 0x400.
    burst(0, 30'h3FE, 3, 2, -1);
    // Byte-lane write then read back.
    single(1, 30'h020, 4'b0011, 32'h1234_5678, '0, 0);
    single(0, 30'h020, 4'h0, '0, 32'hFFFF_5678, 0);

    // Abort in WAIT: CYC drops before the response, nothing is written.
    @(posedge clk); #1;
    drv(1, 1, 0, 1, 30'h030, 4'hF, 32'h1111_1111);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, '0, '0, '0);
    repeat (4) @(negedge clk);
    check("abort_quiet", {30'd0, ACK_O, ERR_O}, 32'd0);
    single(0, 30'h030, 4'h0, '0, 32'hDEAD_0030, 0);

    // Top of the address space is out of window.
    single(0, 30'h3FFF_FFFF, 4'h0, '0, '0, 1);
    single(0, 30'h000_0400, 4'h0, '0, '0, 1);
    single(0, 30'h3FF, 4'h0, '0, 32'h0000_03FF, 0);

    // Reset asserted during the 3rd ACK of a burst, then a normal read.
    burst(0, 30'h010, 8, -1, 2);
    RST_I = 1'b0;
    single(0, 30'h017, 4'h0, '0, 32'h0000_0017, 0);

    repeat (5) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses missing, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_vmem_slave.md
# vga_vmem_slave

WISHBONE slave that serves the 32-bit read and write cycles issued by the VGA WISHBONE master, backed by an internal 2^AW-word memory.
- Used as the video-memory and CLUT target in the core's simulation environment and in standalone FPGA builds.
- Supports classic single cycles and CAB linear bursts, with programmable first-beat and burst-beat wait states.
- Signals ERR_O for addresses outside its window.
- A zero-wait burst path prefetches the next word so ACK_O can stay high every cycle.

## Interface
- AW, 10: memory depth is 2^AW 32-bit words.
- BASE, 0: window select, compared with ADR_I[31:AW+2]. Width is 30-AW bits.
- WAIT_FIRST, 2: wait states before the first beat of a cycle. Range 0..15.
- WAIT_BURST, 0: wait states before each subsequent CAB beat. Range 0..15.
- CLK_I  in  1  clock; all state changes on its rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- CYC_I  in  1  cycle valid.
- STB_I  in  1  strobe.
- CAB_I  in  1  consecutive address burst.
- WE_I  in  1  write enable.
- ADR_I  in  30  word address [31:2].
- SEL_I  in  4  byte lane enables for writes.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, valid when ACK_O=1.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination for an out-of-window address.

## Operation
- In range means ADR_I[31:AW+2]==BASE. The index is ADR_I[AW+1:2].
- Internal registers:
  - state: IDLE, WAIT, RESP.
  - adr_q: 30-bit address of the beat being served.
  - we_q, err_q.
  - wcnt: 4 bits.
  - ack_q.
- Memory read is synchronous. DAT_O holds mem[adr_q] in RESP.
- Both outputs are registered flags gated combinationally:
  - ACK_O = ack_q & !err_q & CYC_I & STB_I & (ADR_I==adr_q).
  - ERR_O = ack_q & err_q & CYC_I & STB_I & (ADR_I==adr_q).
- A beat completes only in a cycle where ACK_O or ERR_O is 1.
- IDLE: on CYC_I&STB_I, capture adr_q<=ADR_I, we_q<=WE_I, err_q<=!in_range(ADR_I), and issue the memory read.
  - WAIT_FIRST==0: go to RESP.
  - Otherwise: wcnt<=WAIT_FIRST-1 and go to WAIT.
- WAIT:
  - If !CYC_I, !STB_I, or ADR_I!=adr_q: abort to IDLE. No write, no response.
  - Else if wcnt==0: go to RESP.
  - Else: decrement wcnt.
- RESP with a completed beat:
  - On ACK_O with we_q=1: write DAT_I to mem[adr_q] for each byte lane whose SEL_I bit is set.
  - CAB_I=1 and err_q=0: continue the burst.
    - adr_q<=adr_q+1 (30-bit wrap); err_q<=!in_range(adr_q+1); we_q<=WE_I; prefetch mem[adr_q+1].
    - WAIT_BURST==0: stay in RESP.
    - Otherwise: wcnt<=WAIT_BURST-1 and go to WAIT.
  - Otherwise: go to IDLE.
- RESP without a completed beat (STB_I low, CYC_I low, or address mismatch): go to IDLE. The speculative prefetch is discarded and nothing is written.
- After ERR_O the burst always ends. The master must start a new cycle.
- Memory contents are not affected by reset.

## Timing
- Reset values: state=IDLE, ack_q=0, err_q=0, wcnt=0, adr_q=0, DAT_O=0. ACK_O and ERR_O go to 0 immediately when RST_I rises.
- First-beat latency: STB_I sampled high at edge t gives the response in the cycle after edge t+WAIT_FIRST, i.e. WAIT_FIRST+1 cycles from STB_I rising.
- CAB beats: WAIT_BURST+1 cycles per beat. With WAIT_BURST=0, ACK_O is high on consecutive cycles for a linear burst.
- Non-CAB back-to-back singles: one IDLE cycle between the response and the next capture.
- A write lands in memory at the edge ending the ACK_O cycle. A read of that address issued one cycle later returns the new data.
- Speculative RESP entered while the master drops STB_I produces no ACK_O and no write.
- Boundary conditions:
  - A burst running past the window end gives ERR_O on the first out-of-window beat.
  - Address wrap at 0x3FFF_FFFF→0 is range-checked like any other address.

## Test plan
- Reset mid-burst:
  - Stimulus: assert RST_I asynchronously during the 3rd ACK_O of a burst.
  - Response: ACK_O, ERR_O and DAT_O are 0 before the next edge. A single read issued after reset gets its first ACK_O after WAIT_FIRST+1 cycles.
- Single read:
  - Stimulus: WAIT_FIRST=2, mem[0x005]=0xA5A5_0005, STB_I rises at cycle 0 with ADR_I=0x005.
  - Response: ACK_O=1 only in cycle 3, DAT_O=0xA5A5_0005, ERR_O=0 throughout.
- Linear CAB burst:
  - Stimulus: 8-beat burst from 0x010, mem[i]=i, WAIT_FIRST=2, WAIT_BURST=0. The master drops STB_I the cycle after the 8th ACK.
  - Response: ACK_O high in cycles 3..10 with DAT_O=0x10..0x17, ACK_O=0 in cycle 11.
- Window edge:
  - Stimulus: AW=10, BASE=0, CAB burst from 0x3FE.
  - Response: ACK for 0x3FE and 0x3FF, ERR_O for 0x400, burst ends.
- Byte-lane write:
  - Stimulus: mem[0x020]=0xFFFF_FFFF; write DAT_I=0x1234_5678 with SEL_I=4'b0011; then read 0x020.
  - Response: read returns 0xFFFF_5678.
- Abort in WAIT:
  - Stimulus: WAIT_FIRST=4, write to 0x030, drop CYC_I in cycle 2.
  - Response: no ACK_O, mem[0x030] unchanged. The next single read from 0x030 is acknowledged normally after 5 cycles.
